// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexed 8-digit hex scanner for a common-anode 7-segment display
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   data       32-bit word shown as 8 hex nibbles, nibble k on digit k
//   hold       freezes the displayed snapshot while high
//   blank      turns all digits off while high (scan keeps running)
//   dp_mask    bit k lights the decimal point of digit k
//   seg        active-low segments, seg[7] is the decimal point
//   dig        active-low one-cold digit enables
//   frame_tick one-cycle pulse after the last digit of each frame
// Build option: define SEG7_LZB_EN to blank leading zeros.
module seg7_scanner #(
    parameter int DIV = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        hold,
    input  logic        blank,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  seg,
    output logic [7:0]  dig,
    output logic        frame_tick
);
    // Segment patterns gfedcba (active-low), entry 0 on the right
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    logic [DIV-1:0] pre_q, pre_d;
    logic [2:0]     idx_q, idx_d;
    logic [31:0]    snap_q, snap_d;
    logic [7:0]     seg_q, seg_d, dig_q, dig_d;
    logic           frame_q, frame_d;
    logic           tick, load;
    logic [3:0]     nib;
    logic [6:0]     segs;
    always_comb begin
        tick    = &pre_q;
        load    = tick && idx_q == 3'd7;
        pre_d   = pre_q + DIV'(1);
        idx_d   = idx_q + 3'(tick);
        frame_d = load;
        snap_d  = (load && !hold) ? data : snap_q;
        nib     = snap_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
        // A digit is a leading zero when it and every higher nibble are zero
        segs    = (idx_q != 3'd0 && (snap_q >> {idx_q, 2'b00}) == 32'd0) ? 7'h7F : SEG_LUT[nib];
`else
        segs    = SEG_LUT[nib];
`endif
        seg_d   = blank ? 8'hFF : {~dp_mask[idx_q], segs};
        dig_d   = blank ? 8'hFF : ~(8'd1 << idx_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            seg_q   <= 8'hFF;
            dig_q   <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end
    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_tick = frame_q;
endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: randomized scoreboard bench for seg7_scanner with DIV=2
module tb_seg7_scanner;
    logic        clk = 1'b0;
    logic        rst, hold, blank, frame_tick;
    logic [31:0] data;
    logic [7:0]  dp_mask, seg, dig;
    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] dig;
        logic       ft;
    } exp_t;
    exp_t        q[$];
    exp_t        me;
    int          n_chk = 0, n_fail = 0;
    int          t = 0;
    logic [31:0] snap_m = '0;
    logic [7:0]  lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    always #5 clk = ~clk;
    seg7_scanner #(.DIV(2)) dut (
        .clk(clk), .rst(rst), .data(data), .hold(hold), .blank(blank),
        .dp_mask(dp_mask), .seg(seg), .dig(dig), .frame_tick(frame_tick)
    );
    // Reference: with DIV=2 each digit lasts 4 cycles and a frame 32 cycles,
    // so everything follows from t, the number of edges since reset release.
    task automatic step(input logic r, input logic [31:0] d, input logic h, input logic b, input logic [7:0] m);
        exp_t        e;
        int          k;
        logic [31:0] w;
        logic [6:0]  s7;
        rst = r; data = d; hold = h; blank = b; dp_mask = m;
        if (r) begin
            e.seg = 8'hFF; e.dig = 8'hFF; e.ft = 1'b0;
            t = 0; snap_m = '0;
        end else begin
            k  = (t / 4) % 8;
            w  = snap_m >> (4 * k);
            s7 = lut[w[3:0]][6:0];
`ifdef SEG7_LZB_EN
            if (k > 0 && w == 0) s7 = 7'h7F;
`endif
            e.seg = b ? 8'hFF : {~m[k], s7};
            e.dig = b ? 8'hFF : ~(8'd1 << k);
            e.ft  = (t % 32 == 31);
            if (t % 32 == 31 && !h) snap_m = d;
            t++;
        end
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            n_chk += 3;
            if (seg !== me.seg) begin
                n_fail++;
                $display("FAIL seg at %0t: got %h want %h", $time, seg, me.seg);
            end
            if (dig !== me.dig) begin
                n_fail++;
                $display("FAIL dig at %0t: got %h want %h", $time, dig, me.dig);
            end
            if (frame_tick !== me.ft) begin
                n_fail++;
                $display("FAIL frame_tick at %0t: got %b want %b", $time, frame_tick, me.ft);
            end
        end
    end
    initial begin
        repeat (3) step(1, 32'h0, 0, 0, 8'h00);
        repeat (96) step(0, 32'h01234567, 0, 0, 8'h00);
        repeat (40) step(0, 32'hFFFFFFFF, 1, 0, 8'h00);
        repeat (70) step(0, 32'hFFFFFFFF, 0, 0, 8'h00);
        repeat (13) step(0, 32'hFFFFFFFF, 0, 0, 8'h00);
        repeat (5) step(0, 32'hFFFFFFFF, 0, 1, 8'h00);
        repeat (30) step(0, 32'hFFFFFFFF, 0, 0, 8'h00);
        repeat (70) step(0, 32'h00000800, 0, 0, 8'h04);
        repeat (2) step(1, 32'h0, 0, 0, 8'h00);
        repeat (70) step(0, 32'h00000A00, 0, 0, 8'h00);
        repeat (17) step(0, 32'h00000A00, 0, 0, 8'h00);
        repeat (2) step(1, 32'h00000A00, 0, 0, 8'h00);
        repeat (40) step(0, 32'h00000A00, 0, 0, 8'h00);
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d = d >> (4 * $urandom_range(1, 7));
            step($urandom_range(0, 299) == 0, d, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, 8'($urandom));
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
